sar_search: RTL and testbench

- Sequential successive-approximation search engine that sits on the far side of the team's 4-bit magnitude comparator.
- It drives a candidate value (guess) onto the comparator's first operand; the hidden target value sits on the second operand.
- It consumes the eq/lt/gt flags and converges on the target by binary search.
- It reports the recovered value, the probe count, and an error if the flags are inconsistent.

---
 rtl/sar_search.sv | 141 ++++++++++++++
 tb/tb_sar_search.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// sar_search -- successive-approximation search against an external
// combinational magnitude comparator.
//
// The engine drives a candidate (guess) onto comparator operand a, samples the
// eq/lt/gt flags once per SEARCH edge, and narrows a [lo, hix) range by binary
// search until the target is matched, the range is exhausted, or the flags are
// inconsistent.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           begin a search (sampled only in IDLE)
//   guess           registered candidate driven to the comparator
//   cmp_eq/lt/gt    comparator flags for the current guess
//   busy            high while searching
//   done            one-cycle pulse after the terminating edge
//   found / err     outcome of the last search, held until the next start
//   result          matched value (valid when found)
//   probes          comparisons used by the last or current search
module sar_search #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    input  logic             cmp_gt,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [CW-1:0]    probes
);

    typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} state_t;

    state_t           state, state_nx;
    // lo is inclusive, hix exclusive; both need one extra bit so hix can
    // hold 2^WIDTH and lo can step past the top value.
    logic [WIDTH:0]   lo, lo_nx, hix, hix_nx;
    logic [WIDTH:0]   lo_upd, hix_upd;
    logic [WIDTH-1:0] guess_nx, result_nx;
    logic [CW-1:0]    probes_nx;
    logic             done_nx, found_nx, err_nx;
    logic             one_hot;

    assign busy    = (state == SEARCH);
    assign one_hot = ({cmp_eq, cmp_lt, cmp_gt} == 3'b100) ||
                     ({cmp_eq, cmp_lt, cmp_gt} == 3'b010) ||
                     ({cmp_eq, cmp_lt, cmp_gt} == 3'b001);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            lo     <= '0;
            hix    <= '0;
            guess  <= '0;
            result <= '0;
            probes <= '0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            lo     <= lo_nx;
            hix    <= hix_nx;
            guess  <= guess_nx;
            result <= result_nx;
            probes <= probes_nx;
            done   <= done_nx;
            found  <= found_nx;
            err    <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        lo_nx     = lo;
        hix_nx    = hix;
        guess_nx  = guess;
        result_nx = result;
        probes_nx = probes;
        done_nx   = 1'b0;
        found_nx  = found;
        err_nx    = err;
        lo_upd    = lo;
        hix_upd   = hix;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = SEARCH;
                    lo_nx     = '0;
                    hix_nx    = {1'b1, {WIDTH{1'b0}}};
                    guess_nx  = {1'b1, {(WIDTH-1){1'b0}}};
                    probes_nx = '0;
                    found_nx  = 1'b0;
                    err_nx    = 1'b0;
                    result_nx = '0;
                end
            end

            SEARCH: begin
                probes_nx = probes + CW'(1);
                if (!one_hot) begin
                    // Broken comparator or floating flags: abort, result stays 0.
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    err_nx   = 1'b1;
                    found_nx = 1'b0;
                end else if (cmp_eq) begin
                    state_nx  = IDLE;
                    done_nx   = 1'b1;
                    found_nx  = 1'b1;
                    result_nx = guess;
                end else begin
                    if (cmp_lt)
                        lo_upd  = {1'b0, guess} + {{WIDTH{1'b0}}, 1'b1};
                    else
                        hix_upd = {1'b0, guess};
                    lo_nx  = lo_upd;
                    hix_nx = hix_upd;
                    if (lo_upd >= hix_upd) begin
                        // Empty range: target is not reachable with these flags.
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        // Sum needs WIDTH+2 bits; the midpoint always fits WIDTH.
                        guess_nx = WIDTH'(({1'b0, lo_upd} + {1'b0, hix_upd}) >> 1);
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: drivers push the hand-computed outcome of
// each search; a monitor pops and compares on every done pulse.
module tb_sar_search;

    localparam int W  = 4;
    localparam int CW = 3;

    localparam logic [1:0] M_NORM = 2'd0;  // honest comparator
    localparam logic [1:0] M_LT   = 2'd1;  // always "guess < target"
    localparam logic [1:0] M_GT   = 2'd2;  // always "guess > target"
    localparam logic [1:0] M_ILL  = 2'd3;  // lt&gt on second probe

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  guess;
    logic          cmp_eq, cmp_lt, cmp_gt;
    logic          busy, done, found, err;
    logic [W-1:0]  result;
    logic [CW-1:0] probes;

    logic [W-1:0]  target = '0;
    logic [1:0]    mode = M_NORM;

    typedef struct packed {
        logic [7:0]      id;
        logic            found;
        logic            err;
        logic [3:0]      result;
        logic [2:0]      probes;
        logic [3:0]      nseq;   // 0 = don't check guess sequence
        logic [5:0][3:0] seq;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   n_done = 0;
    logic [3:0] seen [8];
    int   seen_n = 0;

    sar_search #(.WIDTH(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .guess(guess),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_gt(cmp_gt),
        .busy(busy), .done(done), .found(found), .err(err),
        .result(result), .probes(probes)
    );

    always #5 clk = ~clk;

    // Comparator environment model.
    always_comb begin
        cmp_eq = (guess == target);
        cmp_lt = (guess <  target);
        cmp_gt = (guess >  target);
        case (mode)
            M_LT:  begin cmp_eq = 1'b0; cmp_lt = 1'b1; cmp_gt = 1'b0; end
            M_GT:  begin cmp_eq = 1'b0; cmp_lt = 1'b0; cmp_gt = 1'b1; end
            M_ILL: if (probes == 3'd1) begin cmp_eq = 1'b0; cmp_lt = 1'b1; cmp_gt = 1'b1; end
            default: ;
        endcase
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: record probed guesses, compare outcome on each done pulse.
    always @(negedge clk) begin
        if (rst) begin
            seen_n = 0;
        end else begin
            if (busy && seen_n < 8) begin
                seen[seen_n] = guess;
                seen_n++;
            end
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("[TB] search %0d done: found=%0d err=%0d result=%0d probes=%0d",
                             e.id, found, err, result, probes);
                    check($sformatf("s%0d_found", e.id), found, e.found);
                    check($sformatf("s%0d_err", e.id), err, e.err);
                    check($sformatf("s%0d_result", e.id), result, e.result);
                    check($sformatf("s%0d_probes", e.id), probes, e.probes);
                    check($sformatf("s%0d_busy", e.id), busy, 0);
                    if (e.nseq != 0) begin
                        check($sformatf("s%0d_nguess", e.id), seen_n, e.nseq);
                        for (int i = 0; i < int'(e.nseq) && i < seen_n; i++)
                            check($sformatf("s%0d_guess%0d", e.id, i), seen[i], e.seq[i]);
                    end
                end
                seen_n = 0;
            end
        end
    end

    function automatic exp_t mk(int id, bit f, bit er, int r, int p);
        exp_t e;
        e        = '0;
        e.id     = 8'(id);
        e.found  = f;
        e.err    = er;
        e.result = 4'(r);
        e.probes = 3'(p);
        return e;
    endfunction

    task automatic wait_done();
        int d0;
        d0 = n_done;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (n_done != d0) return;
        end
        check("done_timeout", 0, 1);
        sb.delete();
    endtask

    task automatic go(logic [3:0] t, logic [1:0] m, exp_t e);
        @(negedge clk);
        target = t;
        mode   = m;
        start  = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    task automatic wait_done_posedge();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) return;
        end
        check("done_pulse_timeout", 0, 1);
    endtask

    initial begin
        exp_t e;
        int   d0;
        int   ptbl [16];
        ptbl = '{5, 4, 3, 4, 2, 4, 3, 4, 1, 4, 3, 4, 2, 4, 3, 4};

        // Reset state.
        #12;
        check("rst_guess", guess, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        check("rst_probes", probes, 0);
        @(negedge clk);
        rst = 1'b0;

        // Midpoint hit.
        e = mk(1, 1, 0, 8, 1); e.nseq = 1; e.seq[0] = 8;
        go(4'd8, M_NORM, e);
        repeat (3) @(negedge clk);
        check("hold_found", found, 1);
        check("hold_result", result, 8);
        check("hold_probes", probes, 1);
        check("hold_guess", guess, 8);

        // Bottom and top boundaries with guess sequences.
        e = mk(2, 1, 0, 0, 5); e.nseq = 5;
        e.seq[0] = 8; e.seq[1] = 4; e.seq[2] = 2; e.seq[3] = 1; e.seq[4] = 0;
        go(4'd0, M_NORM, e);
        e = mk(3, 1, 0, 15, 4); e.nseq = 4;
        e.seq[0] = 8; e.seq[1] = 12; e.seq[2] = 14; e.seq[3] = 15;
        go(4'd15, M_NORM, e);

        // Full sweep.
        for (int t = 0; t < 16; t++)
            go(4'(t), M_NORM, mk(10 + t, 1, 0, t, ptbl[t]));

        // Illegal flags on the second probe.
        go(4'd3, M_ILL, mk(30, 0, 1, 0, 2));

        // Range exhaustion: always-lt walks up to lo=16 after 4 probes;
        // always-gt walks down to hix=0 after 5 probes.
        go(4'd15, M_LT, mk(31, 0, 0, 0, 4));
        go(4'd15, M_GT, mk(32, 0, 0, 0, 5));

        // Start held high for a whole search: guesses 8,4,6.
        d0 = n_done;
        @(negedge clk);
        target = 4'd6; mode = M_NORM; start = 1'b1;
        e = mk(40, 1, 0, 6, 3); e.nseq = 3;
        e.seq[0] = 8; e.seq[1] = 4; e.seq[2] = 6;
        sb.push_back(e);
        wait_done_posedge();
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("held_start_one_done", n_done, d0 + 1);
        check("held_start_idle", busy, 0);

        // Start in the done cycle: 10 then 5 back to back.
        @(negedge clk);
        target = 4'd10; start = 1'b1;
        sb.push_back(mk(41, 1, 0, 10, 3));
        @(negedge clk);
        start = 1'b0;
        wait_done_posedge();
        target = 4'd5; start = 1'b1;
        e = mk(42, 1, 0, 5, 4); e.nseq = 4;
        e.seq[0] = 8; e.seq[1] = 4; e.seq[2] = 6; e.seq[3] = 5;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_guess", guess, 8);
        wait_done();

        // Asynchronous reset mid-search (target 3, after 2 probes).
        d0 = n_done;
        @(negedge clk);
        target = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_guess", guess, 0);
        check("arst_probes", probes, 0);
        check("arst_result", result, 0);
        check("arst_done", done, 0);
        check("arst_found", found, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("arst_no_done", n_done, d0);
        check("arst_idle", busy, 0);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
